// File: rtl/hplvds_pkg.sv
// Shared types and defaults for the HPLVDS transmit/receive serializer blocks.
package hplvds_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_IDLE   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DRAIN  = 3'd4
    } tx_state_e;

    localparam int HPLVDS_WORD_W     = 8;
    localparam int HPLVDS_SETTLE_CYC = 16;

endpackage

// File: rtl/hplvds_tx_ser_if.sv
// Parallel word handshake feeding the HPLVDS serializer.
interface hplvds_tx_ser_if
    import hplvds_pkg::*;
#(
    parameter int WORD_W = HPLVDS_WORD_W
) ();

    logic              s_valid_i;
    logic [WORD_W-1:0] s_data_i;
    logic              s_ready_o;

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o
    );

endinterface

// File: rtl/hplvds_settle_cnt.sv
// Loadable down-counter with a zero flag; times pad bias settling on both
// the transmit and receive sides.
module hplvds_settle_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             dec,
    output logic             isZero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && !isZero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign isZero = (count == '0);

endmodule

// File: rtl/hplvds_tx_ser.sv
// HPLVDS transmit serializer: LSB-first word shifting plus the pad enable /
// common-mode / electrical-idle sequencing around it.
module hplvds_tx_ser
    import hplvds_pkg::*;
#(
    parameter int WORD_W     = HPLVDS_WORD_W,
    parameter int SETTLE_CYC = HPLVDS_SETTLE_CYC
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en_i,
    hplvds_tx_ser_if.slave s,
    output logic           tx_en_o,
    output logic           tx_vcm_en_o,
    output logic           tx_ei_o,
    output logic           do_o,
    output logic           settled_o,
    output logic           busy_o
);

    localparam int BIT_CNT_W = $clog2(WORD_W);
    localparam int CNT_W     = $clog2(SETTLE_CYC + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

    tx_state_e             state, nextState;
    logic [WORD_W-1:0]     shiftReg;
    logic [BIT_CNT_W-1:0]  bitCnt, nextBitCnt;
    logic                  dropReq, nextDropReq;
    logic                  sReady;
    logic                  accept, lastBit;
    logic                  cntLoad, cntDec, settleDone;

    // en_i must still be high on the accepting edge; a same-cycle disable wins.
    assign accept     = sReady && s.s_valid_i && en_i;
    assign lastBit    = (bitCnt == LAST_BIT);
    assign s.s_ready_o = sReady;
    assign do_o       = shiftReg[0];

    hplvds_settle_cnt #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load    (cntLoad),
        .loadVal (CNT_W'(SETTLE_CYC - 1)),
        .dec     (cntDec),
        .isZero  (settleDone)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        nextState   = state;
        nextBitCnt  = '0;
        nextDropReq = 1'b0;
        cntLoad     = 1'b0;
        cntDec      = 1'b0;
        case (state)
            ST_OFF: begin
                if (en_i) begin
                    nextState = ST_SETTLE;
                    cntLoad   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!en_i)           nextState = ST_OFF;
                else if (settleDone) nextState = ST_IDLE;
                else                 cntDec    = 1'b1;
            end
            ST_IDLE: begin
                if (accept)     nextState = ST_SHIFT;
                else if (!en_i) nextState = ST_OFF;
            end
            ST_SHIFT: begin
                // A disable seen anywhere in the word is remembered until its last bit.
                nextDropReq = dropReq || !en_i;
                if (!lastBit) begin
                    nextBitCnt = bitCnt + BIT_CNT_W'(1);
                end else if (accept) begin
                    nextDropReq = 1'b0;
                end else if (nextDropReq) begin
                    nextState = ST_DRAIN;
                end else begin
                    nextState = ST_IDLE;
                end
            end
            ST_DRAIN: nextState = ST_OFF;
            default:  nextState = ST_OFF;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_OFF;
            bitCnt      <= '0;
            dropReq     <= 1'b0;
            shiftReg    <= '0;
            sReady      <= 1'b0;
            tx_en_o     <= 1'b0;
            tx_vcm_en_o <= 1'b0;
            tx_ei_o     <= 1'b0;
            settled_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= nextState;
            bitCnt      <= nextBitCnt;
            dropReq     <= nextDropReq;
            // Zeros shift in behind the word, so do_o is already 0 when it ends.
            shiftReg    <= accept ? s.s_data_i : (shiftReg >> 1);
            sReady      <= (nextState == ST_IDLE) ||
                           ((nextState == ST_SHIFT) && (nextBitCnt == LAST_BIT) && !nextDropReq);
            tx_en_o     <= (nextState != ST_OFF);
            tx_vcm_en_o <= (nextState != ST_OFF);
            tx_ei_o     <= nextState inside {ST_SETTLE, ST_IDLE, ST_DRAIN};
            settled_o   <= nextState inside {ST_IDLE, ST_SHIFT};
            busy_o      <= nextState inside {ST_SHIFT, ST_DRAIN};
        end
    end

endmodule

// File: tb/tb_hplvds_tx_ser.sv
// Directed + randomized bench for hplvds_tx_ser; expected pad activity is
// derived from the word timing rules (bit k on do_o k edges after the handshake).
module tb_hplvds_tx_ser;

    localparam int W  = 8;
    localparam int SC = 16;

    // Expected output vectors, ordered {tx_en, tx_vcm_en, tx_ei, s_ready, busy, settled, do}.
    localparam logic [6:0] OFF_V    = 7'b000_0000;
    localparam logic [6:0] SETTLE_V = 7'b111_0000;
    localparam logic [6:0] IDLE_V   = 7'b111_1010;
    localparam logic [6:0] DRAIN_V  = 7'b111_0100;

    logic clk = 1'b0;
    logic rstN;
    logic en;
    logic txEn, txVcmEn, txEi, dOut, settled, busy;

    int nCompared = 0;
    int nMismatch = 0;

    logic [W-1:0] wq[$];
    int           gq[$];

    hplvds_tx_ser_if #(.WORD_W(W)) txBus ();

    hplvds_tx_ser #(
        .WORD_W     (W),
        .SETTLE_CYC (SC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .en_i        (en),
        .s           (txBus.slave),
        .tx_en_o     (txEn),
        .tx_vcm_en_o (txVcmEn),
        .tx_ei_o     (txEi),
        .do_o        (dOut),
        .settled_o   (settled),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] obsVec();
        return {txEn, txVcmEn, txEi, txBus.s_ready_o, busy, settled, dOut};
    endfunction

    function automatic logic [6:0] shiftVec(input logic rdy, input logic b);
        return {3'b110, rdy, 2'b11, b};
    endfunction

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatch++;
            $error("FAIL %s: observed %b expected %b (tx_en,vcm,ei,rdy,busy,settled,do)",
                   tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic [6:0] expV, input string tag);
        txBus.s_valid_i = v;
        txBus.s_data_i  = d;
        tick();
        check(tag, obsVec(), expV);
    endtask

    // From OFF with en already high: SETTLE for SC edges, ready after edge SC.
    task automatic settle(input string tag);
        for (int c = 0; c <= SC; c++) begin
            tick();
            check($sformatf("%s[%0d]", tag, c), obsVec(), (c == SC) ? IDLE_V : SETTLE_V);
        end
    endtask

    // Streams wq from IDLE; gq[i] idle edges precede word i, 0 means back-to-back.
    task automatic runStream(input string tag);
        logic [W-1:0] w;
        logic         nxtBack;
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            for (int j = 0; j < gq[i]; j++)
                step(1'b0, '0, IDLE_V, $sformatf("%s_gap%0d_%0d", tag, i, j));
            step(1'b1, w, shiftVec(1'b0, w[0]), $sformatf("%s_w%0d_b0", tag, i));
            nxtBack = (i + 1 < wq.size()) && (gq[i + 1] == 0);
            for (int k = 1; k < W; k++)
                step(nxtBack, nxtBack ? wq[i + 1] : '0, shiftVec(k == W - 1, w[k]),
                     $sformatf("%s_w%0d_b%0d", tag, i, k));
        end
        step(1'b0, '0, IDLE_V, $sformatf("%s_tail", tag));
    endtask

    initial begin
        rstN = 1'b0;
        en   = 1'b0;
        txBus.s_valid_i = 1'b0;
        txBus.s_data_i  = '0;
        #1 check("reset_async", obsVec(), OFF_V);
        repeat (2) tick();
        check("reset_hold", obsVec(), OFF_V);
        #2 rstN = 1'b1;
        tick();
        check("off_no_en", obsVec(), OFF_V);

        en = 1'b1;
        settle("settle0");

        wq.delete(); gq.delete();
        wq.push_back(8'hA5); gq.push_back(0);
        runStream("a5");

        wq.delete(); gq.delete();
        wq.push_back(8'h0F); gq.push_back(0);
        wq.push_back(8'hF0); gq.push_back(0);
        runStream("b2b");

        wq.delete(); gq.delete();
        for (int i = 0; i < 12; i++) begin
            wq.push_back(W'($urandom));
            gq.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        runStream("rnd");

        // Disable during bit 3 of 8'hFF: word completes, one DRAIN cycle, then OFF.
        step(1'b1, 8'hFF, shiftVec(1'b0, 1'b1), "dis_b0");
        for (int k = 1; k <= 3; k++)
            step(1'b0, '0, shiftVec(1'b0, 1'b1), $sformatf("dis_b%0d", k));
        en = 1'b0;
        for (int k = 4; k < W; k++)
            step(1'b1, 8'h3C, shiftVec(1'b0, 1'b1), $sformatf("dis_b%0d", k));
        step(1'b1, 8'h3C, DRAIN_V, "dis_drain");
        step(1'b1, 8'h3C, OFF_V, "dis_off");
        step(1'b1, 8'h3C, OFF_V, "dis_off_hold");
        txBus.s_valid_i = 1'b0;

        // Disable and valid together in IDLE: no acceptance, straight to OFF.
        en = 1'b1;
        settle("settle1");
        en = 1'b0;
        step(1'b1, 8'h81, OFF_V, "clash_off");
        step(1'b1, 8'h81, OFF_V, "clash_hold");
        txBus.s_valid_i = 1'b0;

        // Disable during SETTLE aborts the wait.
        en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("abort_settle[%0d]", c), obsVec(), SETTLE_V);
        end
        en = 1'b0;
        tick();
        check("abort_off", obsVec(), OFF_V);

        // Asynchronous reset mid-word, then the full settle wait repeats.
        en = 1'b1;
        settle("settle2");
        step(1'b1, 8'h5A, shiftVec(1'b0, 1'b0), "rst_b0");
        step(1'b0, '0, shiftVec(1'b0, 1'b1), "rst_b1");
        step(1'b0, '0, shiftVec(1'b0, 1'b0), "rst_b2");
        #2 rstN = 1'b0;
        #1 check("rst_immediate", obsVec(), OFF_V);
        repeat (2) tick();
        check("rst_held", obsVec(), OFF_V);
        #2 rstN = 1'b1;
        settle("settle3");

        wq.delete(); gq.delete();
        wq.push_back(W'($urandom)); gq.push_back(1);
        runStream("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/hplvds_tx_ser.md
# hplvds_tx_ser

Transmit-side serializer and enable sequencer for one HPLVDS pad pair. It accepts parallel words over a valid/ready handshake and shifts them out LSB-first, one bit per clock, on the pad's data input. It also sequences the pad's transmitter enable, common-mode enable and electrical-idle controls, so the pad never drives data before its bias has settled. It sits in the core power domain, directly upstream of the HPLVDS pad cell.

## Interface
- WORD_W, 8, serialized word width; ≥2.
- SETTLE_CYC, 16, cycles the pad sits in electrical idle after enable before the first data is accepted; ≥1.
- clk_i  in  1  bit clock; one serial bit per rising edge.
- rst_ni  in  1  reset, asynchronous, active-low (decided: one clock; async active-low reset).
- en_i  in  1  link enable request.
- s_valid_i  in  1  word valid.
- s_data_i  in  WORD_W  word to transmit; bit 0 is sent first.
- s_ready_o  out  1  word accepted when s_valid_i && s_ready_o at a rising edge.
- tx_en_o  out  1  drives pad TX_EN_I.
- tx_vcm_en_o  out  1  drives pad TX_VCM_EN_I.
- tx_ei_o  out  1  drives pad TX_EI_I; 1 forces electrical idle.
- do_o  out  1  drives pad DO_I.
- settled_o  out  1  high in IDLE and SHIFT.
- busy_o  out  1  high in SHIFT and DRAIN.

## Operation
- All outputs are registered. Reset value of every output is 0.
- **OFF:** all outputs are 0.
  - en_i=1 → SETTLE, and the settle counter loads SETTLE_CYC-1.
- **SETTLE:** tx_en_o=tx_vcm_en_o=tx_ei_o=1, do_o=0.
  - The counter decrements each cycle.
  - Counter at 0 → IDLE.
  - en_i=0 → OFF next cycle.
- **IDLE:** tx_en_o=tx_vcm_en_o=tx_ei_o=1, do_o=0, s_ready_o=1.
  - Handshake → SHIFT: s_data_i is loaded into the shift register and bit_cnt is set to 0.
  - en_i=0 (without a handshake) → OFF.
  - en_i=0 and s_valid_i=1 in the same cycle: en_i wins, the word is not accepted, and s_ready_o drops next cycle.
- **SHIFT:** tx_ei_o=0, do_o=current shift-register bit 0, bit_cnt counts 0..WORD_W-1.
  - s_ready_o=1 only while bit_cnt==WORD_W-1 and en_i=1.
  - Handshake on the last bit: reload, bit_cnt=0, stay in SHIFT. The next word follows with no idle gap.
  - Last bit with no handshake and en_i=1 → IDLE; tx_ei_o returns to 1 next cycle.
  - en_i=0 at any point in SHIFT: the word in flight completes, no new word is accepted, and the state goes to DRAIN after the last bit.
- **DRAIN:** one cycle with tx_ei_o=1, tx_en_o=1, do_o=0, then OFF. The pad is quiesced through idle before the transmitter is disabled.
- bit_cnt width is $clog2(WORD_W). It never wraps past WORD_W-1. The settle counter width is $clog2(SETTLE_CYC+1).
- Reset asserted mid-operation: immediate return to OFF with all outputs 0. The in-flight word is discarded.

## Timing
- en_i rises before edge 0 → tx_en_o=1 after edge 0. s_ready_o=1 after edge SETTLE_CYC.
- Handshake at edge N → do_o=bit0 and tx_ei_o=0 after edge N. Bit k is on do_o after edge N+k.
- Steady streaming: exactly WORD_W cycles per word and 100% bit utilization.
- Disable: en_i falls during bit k → the last bit is driven after edge N+WORD_W-1. DRAIN follows after edge N+WORD_W, and tx_en_o=0 after edge N+WORD_W+1.
- No combinational path from any input to any output.

## Structure
- Package hplvds_pkg holds:
  - the state enum tx_state_e (OFF, SETTLE, IDLE, SHIFT, DRAIN);
  - the default constants HPLVDS_WORD_W=8 and HPLVDS_SETTLE_CYC=16.
- One sub-module, hplvds_settle_cnt: a loadable down-counter with a zero flag. The receive-side deserializer will reuse it.
- The shift register, bit counter and FSM stay in the top level.

## Test plan
- Reset release then en_i=1 with SETTLE_CYC=16 → tx_en_o/tx_vcm_en_o/tx_ei_o=1 from cycle 1; s_ready_o=1 exactly at cycle 16; do_o=0 throughout.
- Single word 8'hA5 → do_o sequence 1,0,1,0,0,1,0,1 with tx_ei_o=0 for exactly 8 cycles, then tx_ei_o=1.
- Back-to-back 8'h0F, 8'hF0 with s_valid_i held → 16 consecutive data cycles with no tx_ei_o gap; s_ready_o pulses only on bit 7.
- en_i dropped at bit 3 of 8'hFF → all 8 bits still sent, one DRAIN idle cycle, then all outputs 0; no further handshake.
- en_i=0 and s_valid_i=1 in the same IDLE cycle → word not accepted, state OFF, tx_en_o=0 next cycle.
- rst_ni asserted asynchronously mid-word → all outputs 0 immediately; after release with en_i=1, the full SETTLE_CYC wait repeats.
